// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: bundles the receive-side push, the consumer pop/clear
// strobes and the FIFO status outputs of uart_rx_fifo.
//
// Handshake semantics: rx_byte_ready is a level from the receiver, and
// rx_byte is valid whenever it is high. The FIFO accepts one byte per rising
// edge of that level, so it has no ready back-pressure. Overflow is signalled
// through the sticky overrun flag. pop and clr_overrun are single-cycle
// strobes from the consumer. head_byte is meaningful only while empty is low.
interface uart_rx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]    rx_byte;
  logic          rx_byte_ready;
  logic          pop;
  logic          clr_overrun;
  logic [7:0]    head_byte;
  logic          empty;
  logic          full;
  logic [ADDR_W:0] count;
  logic          overrun;

  // Producer/consumer side: drives the strobes and reads the status.
  modport master (
    output rx_byte, rx_byte_ready, pop, clr_overrun,
    input  head_byte, empty, full, count, overrun
  );

  // FIFO side.
  modport slave (
    input  rx_byte, rx_byte_ready, pop, clr_overrun,
    output head_byte, empty, full, count, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO behind uart_rx.
// A rising edge of rx_byte_ready pushes one byte. pop discards the head
// entry. overrun is a sticky flag that is set when a byte arrives while
// the FIFO is full.
// Optional feature: define UART_RX_FIFO_OVERWRITE_EN so that a push into a
// full FIFO replaces the oldest byte. Without the macro, the incoming byte
// is dropped.
module uart_rx_fifo #(
  parameter int ADDR_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  uart_rx_fifo_if.slave bus
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  // Storage is not reset. Only the pointers and the count define validity.
  logic [7:0]        mem_q [2**ADDR_W];

  logic              rdy_q, rdy_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overrun_q, overrun_d;

  logic              empty;
  logic              full;
  logic              push_evt;
  logic              pop_ok;
  logic              push_room;
  logic              overflow;
  logic              wr_en;
  logic              rd_adv;

  // Status flags decode straight from the registered count.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == DEPTH_CNT);
  end

  // Classify this cycle's push and pop, then derive the next pointer, count and flag values.
  always_comb begin
    push_evt  = bus.rx_byte_ready & ~rdy_q;
    pop_ok    = bus.pop & ~empty;
    // A full FIFO still takes a push when a pop frees the head in the same cycle.
    push_room = push_evt & (~full | bus.pop);
    overflow  = push_evt & full & ~bus.pop;

`ifdef UART_RX_FIFO_OVERWRITE_EN
    // When overwriting, the new byte goes to the oldest slot. The read pointer
    // moves past that slot, so the count stays at DEPTH.
    wr_en  = push_room | overflow;
    rd_adv = pop_ok | overflow;
`else
    wr_en  = push_room;
    rd_adv = pop_ok;
`endif

    rdy_d    = bus.rx_byte_ready;
    wr_ptr_d = wr_en  ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = rd_adv ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    count_d = count_q;
    if (push_room && !pop_ok) begin
      count_d = count_q + CNT_ONE;
    end else if (!push_room && pop_ok) begin
      count_d = count_q - CNT_ONE;
    end

    // If set and clear happen in the same cycle, set wins.
    overrun_d = overrun_q;
    if (overflow) begin
      overrun_d = 1'b1;
    end else if (bus.clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  // Control state register. rdy_q resets high, so a ready level that is held
  // across reset release does not push a byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy_q     <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      rdy_q     <= rdy_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Byte storage write port. Reset blocks any write in that cycle.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem_q[wr_ptr_q] <= bus.rx_byte;
    end
  end

  assign bus.head_byte = mem_q[rd_ptr_q];
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = count_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo with ADDR_W = 2 (depth 4).
// A table of per-cycle vectors covers reset release and basic FIFO order.
// Hand-written sequences cover overflow, push/pop on a full FIFO, the race
// between set and clear of overrun, pointer wrap and a reset mid-stream.
module tb_uart_rx_fifo;

  localparam int ADDR_W = 2;

  logic clk;
  logic rst_n;

  uart_rx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_rx_fifo #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rdy;
    logic [7:0] b;
    logic       pop;
    logic       clr;
    logic [2:0] cnt;
    logic       emp;
    logic       ful;
    logic       ovr;
    logic       chk_head;
    logic [7:0] head;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rdy, input logic [7:0] b, input logic pop,
                              input logic [2:0] cnt, input logic emp, input logic chk_head,
                              input logic [7:0] head);
    vec_t v;
    v.rdy = rdy; v.b = b; v.pop = pop; v.clr = 1'b0;
    v.cnt = cnt; v.emp = emp; v.ful = (cnt == 3'd4); v.ovr = 1'b0;
    v.chk_head = chk_head; v.head = head;
    vecs.push_back(v);
  endfunction

  // Scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] cnt, input logic ovr);
    chk({tag, " count"}, 32'(bus.count), 32'(cnt));
    chk({tag, " empty"}, 32'(bus.empty), 32'(cnt == 3'd0));
    chk({tag, " full"}, 32'(bus.full), 32'(cnt == 3'd4));
    chk({tag, " overrun"}, 32'(bus.overrun), 32'(ovr));
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.rx_byte = b;
    bus.rx_byte_ready = 1'b1;
    step();
    bus.rx_byte_ready = 1'b0;
    step();
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    chk({tag, " head"}, 32'(bus.head_byte), 32'(exp));
    bus.pop = 1'b1;
    step();
    bus.pop = 1'b0;
  endtask

  initial begin
    logic [7:0] base;

    // Vectors: reset release with ready held, then one fresh push.
    add(1'b1, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00);
    add(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00);
    add(1'b1, 8'h41, 1'b0, 3'd1, 1'b0, 1'b1, 8'h41);
    add(1'b1, 8'h41, 1'b0, 3'd1, 1'b0, 1'b1, 8'h41);
    add(1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00);
    // Three bytes, each with ready held high for 5 cycles.
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 5; c++)
        add(1'b1, 8'(8'h10 * (k + 1)), 1'b0, 3'(k + 1), 1'b0, 1'b1, 8'h10);
      add(1'b0, 8'h00, 1'b0, 3'(k + 1), 1'b0, 1'b1, 8'h10);
    end
    // Pops in order, then a pop while the FIFO is empty.
    add(1'b0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b1, 8'h20);
    add(1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 1'b1, 8'h30);
    add(1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00);
    add(1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00);

    rst_n = 1'b0;
    bus.rx_byte = 8'h00;
    bus.rx_byte_ready = 1'b1;
    bus.pop = 1'b0;
    bus.clr_overrun = 1'b0;
    step();
    step();
    chk_state("reset", 3'd0, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      bus.rx_byte_ready = vecs[i].rdy;
      bus.rx_byte = vecs[i].b;
      bus.pop = vecs[i].pop;
      bus.clr_overrun = vecs[i].clr;
      step();
      chk($sformatf("vec%0d count", i), 32'(bus.count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d empty", i), 32'(bus.empty), 32'(vecs[i].emp));
      chk($sformatf("vec%0d full", i), 32'(bus.full), 32'(vecs[i].ful));
      chk($sformatf("vec%0d overrun", i), 32'(bus.overrun), 32'(vecs[i].ovr));
      if (vecs[i].chk_head)
        chk($sformatf("vec%0d head", i), 32'(bus.head_byte), 32'(vecs[i].head));
    end
    bus.pop = 1'b0;

    // Fill to full, then overflow.
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    chk_state("fill", 3'd4, 1'b0);
    push_byte(8'h05);
    chk_state("overflow", 3'd4, 1'b1);
`ifdef UART_RX_FIFO_OVERWRITE_EN
    base = 8'h02;
`else
    base = 8'h01;
`endif
    for (int i = 0; i < 4; i++) pop_expect($sformatf("ovf_pop%0d", i), base + 8'(i));
    chk_state("ovf_drained", 3'd0, 1'b1);
    bus.clr_overrun = 1'b1;
    step();
    bus.clr_overrun = 1'b0;
    chk_state("ovf_clear", 3'd0, 1'b0);

    // Full FIFO: push and pop in the same cycle.
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    bus.rx_byte = 8'h55;
    bus.rx_byte_ready = 1'b1;
    bus.pop = 1'b1;
    step();
    bus.rx_byte_ready = 1'b0;
    bus.pop = 1'b0;
    chk_state("full_pushpop", 3'd4, 1'b0);
    step();
    pop_expect("fpp0", 8'h02);
    pop_expect("fpp1", 8'h03);
    pop_expect("fpp2", 8'h04);
    pop_expect("fpp3", 8'h55);
    chk_state("fpp_drained", 3'd0, 1'b0);

    // Set and clear of overrun in the same cycle: set wins.
    for (int i = 0; i < 4; i++) push_byte(8'h61 + 8'(i));
    push_byte(8'h65);
    chk_state("race_pre", 3'd4, 1'b1);
    bus.rx_byte = 8'h66;
    bus.rx_byte_ready = 1'b1;
    bus.clr_overrun = 1'b1;
    step();
    bus.rx_byte_ready = 1'b0;
    bus.clr_overrun = 1'b0;
    chk_state("race_setwins", 3'd4, 1'b1);
    bus.clr_overrun = 1'b1;
    step();
    bus.clr_overrun = 1'b0;
    chk_state("race_clear", 3'd4, 1'b0);
    bus.pop = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.pop = 1'b0;
    chk_state("race_drained", 3'd0, 1'b0);

    // Pointer wrap: push/pop pairs go around the ring more than twice.
    for (int i = 0; i < 10; i++) begin
      push_byte(8'hA0 + 8'(i));
      chk($sformatf("wrap%0d count", i), 32'(bus.count), 32'd1);
      pop_expect($sformatf("wrap%0d", i), 8'hA0 + 8'(i));
      chk($sformatf("wrap%0d count_after", i), 32'(bus.count), 32'd0);
    end

    // Reset mid-stream overrides push and pop, and discards all entries.
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    push_byte(8'h45);
    chk_state("pre_rst", 3'd4, 1'b1);
    rst_n = 1'b0;
    bus.rx_byte = 8'h77;
    bus.rx_byte_ready = 1'b1;
    bus.pop = 1'b1;
    step();
    bus.pop = 1'b0;
    chk_state("mid_rst", 3'd0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_state("rst_release_held", 3'd0, 1'b0);
    bus.rx_byte_ready = 1'b0;
    step();
    push_byte(8'h99);
    chk_state("post_rst_push", 3'd1, 1'b0);
    chk("post_rst_head", 32'(bus.head_byte), 32'h99);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
